bist_controller: RTL and testbench
==================================

# bist_controller

Sequencing controller for the AES 8-bit datapath's logic BIST. It generates pseudo-random byte patterns with an internal LFSR and drives them into the datapath under test. It sequences the external `misr` (reset, 17-cycle start phase, compression window aligned to datapath latency) and compares the final signature against a golden value. It sits between the test-access/top-level control and the `misr` + datapath pair, and reports a sticky pass/fail result.

## Interface
**Parameters**
- `WIDTH`, 8: pattern and signature width.
- `PATTERNS`, 256: number of patterns applied, ≥1.
- `WARMUP`, 17: `misr` start-phase length in enabled cycles; must equal the `misr` start count.
- `DUT_LAT`, 2: datapath latency in cycles from `pattern_out` to the response at `misr` `data_in`, ≥0.
- `LFSR_TAPS`, 8'hB8: pattern generator feedback taps.
- `LFSR_SEED`, 8'h01: pattern generator seed; must be nonzero.
- `GOLDEN`, 8'h00: expected signature, set per build.

**Ports**
- `clk` input 1: the single clock.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: level-sampled request, accepted only in IDLE or DONE.
- `abort` input 1: terminates any run.
- `misr_signal` input WIDTH: current `misr` signature.
- `misr_rst` output 1: drives `misr` `rst`.
- `misr_en` output 1: drives `misr` `enable`.
- `bist_mode` output 1: selects `pattern_out` into the datapath input mux.
- `pattern_out` output WIDTH: current LFSR pattern.
- `pattern_valid` output 1: high while `pattern_out` is a live test pattern.
- `busy` output 1: high in every state except IDLE and DONE.
- `done` output 1: high in DONE.
- `pass` output 1: signature match result, valid while `done` is high.

## Operation
- **States:** IDLE → INIT → WARMUP → RUN → FLUSH → CHECK → DONE.
- **IDLE:** all outputs 0. `start`=1 moves the FSM to INIT.
- **INIT (1 cycle):** `misr_rst`=1, LFSR loads `LFSR_SEED`, counters clear, `bist_mode`=1.
- **WARMUP (`WARMUP` cycles):** `misr_en`=1, `pattern_valid`=0. The `misr` only counts its start phase here, so the signature stays at its seed.
- **RUN (`PATTERNS` cycles):** `pattern_valid`=1. The LFSR advances every cycle: next = {q[WIDTH-2:0], ^(q & `LFSR_TAPS`)}. The first pattern is `LFSR_SEED`.
- **FLUSH (`DUT_LAT` cycles; skipped if 0):** `pattern_valid`=0. The pipeline drains.
- **Compression window:** outside WARMUP, `misr_en` = `pattern_valid` delayed by `DUT_LAT` through a shift register. Exactly `PATTERNS` responses are compressed.
- **CHECK (1 cycle):** `misr_en`=0. The `pass` register loads (`misr_signal` == `GOLDEN`).
- **DONE:** `done`=1, `pass` held, `bist_mode`=1.
  - `start`=1 goes to INIT and clears `pass`.
  - `abort`=1 goes to IDLE.
- **`abort`=1 in any busy state:** the FSM goes to IDLE next cycle.
  - `misr_en`, `pattern_valid` and `bist_mode` drop that cycle.
  - The delay line clears.
  - `pass` = 0, and `done` is not asserted.
- **Precedence:** `rst` > `abort` > `start`.
- `start` while busy is ignored.
- **Counter width:** $clog2(max(`WARMUP`, `PATTERNS`, `DUT_LAT`)+1). Counters terminate on equality and do not wrap.

## Timing
- **Reset values:** all outputs 0, state IDLE, delay line 0. `pattern_out` = `LFSR_SEED` (with `pattern_valid`=0).
- **Reset mid-run:** same as abort. The `misr` is reinitialised on the next INIT.
- **Start-to-done latency:** `start` sampled at edge 0 → INIT in cycle 1. `done` rises at cycle `WARMUP`+`PATTERNS`+`DUT_LAT`+3; this is 278 with the defaults.
- **First compressed response:** the first `misr_en` cycle in RUN is RUN cycle `DUT_LAT`. `misr_en` is continuous from then for `PATTERNS` cycles.
- `busy` rises the cycle after `start` is accepted.
- `pass` is stable from the first DONE cycle.

## Structure
- **Package `bist_pkg`:** the state enum `bist_state_t` and default constants `BIST_WARMUP`=17, `BIST_TAPS`=8'hB8, shared with `misr` instantiations.
- **Sub-module `bist_lfsr`:** parameters WIDTH/TAPS/SEED; ports `clk`, `load`, `advance`, `q`.
- `misr` is instantiated beside this block, not inside it.

## Test plan
- **Defaults, `GOLDEN` = model signature:** pulse `start` → `busy` next cycle; `done`=1 and `pass`=1 at cycle 278; `misr_en` high for exactly 17+256 cycles.
- **Pattern sequence:** first RUN patterns are 01, 02, 04, 08, 11; `pattern_valid` is high for exactly 256 cycles.
- **Wrong `GOLDEN`** (model signature ^ 8'h01) → `done`=1, `pass`=0.
- **Abort/reset:** `abort` in RUN cycle 100 → IDLE next cycle, all outputs 0, no `done`. Repeat with `rst` mid-FLUSH, with the same result.
- **Start while busy:** `start` held high through a run → one run only, then immediate restart from DONE; `pass` clears in the INIT cycle.
- **Edge parameters:** `PATTERNS`=1 and `DUT_LAT`=0 → FLUSH skipped, `done` at cycle 21, one compressed response.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared BIST definitions: controller state encoding and defaults used by the
// controller and by the misr instances that sit beside it.
package bist_pkg;
  localparam int         BIST_WARMUP = 17;
  localparam logic [7:0] BIST_TAPS   = 8'hB8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT   = 3'd1,
    S_WARMUP = 3'd2,
    S_RUN    = 3'd3,
    S_FLUSH  = 3'd4,
    S_CHECK  = 3'd5,
    S_DONE   = 3'd6
  } bist_state_t;

  function automatic int max3(int a, int b, int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction
endpackage

// File: rtl/bist_lfsr.sv
// Fibonacci-style pattern generator: shifts left, feedback is the parity of the tapped bits.
module bist_lfsr #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
  parameter logic [WIDTH-1:0] SEED  = 8'h01
) (
  input  logic             clk,
  input  logic             load,
  input  logic             advance,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (load)         q <= SEED;
    else if (advance) q <= {q[WIDTH-2:0], ^(q & TAPS)};
  end
endmodule

// File: rtl/bist_controller.sv
// Logic BIST sequencer: drives LFSR patterns into the datapath, frames the misr
// start phase and compression window, and latches the signature compare result.
module bist_controller import bist_pkg::*; #(
  parameter int               WIDTH     = 8,
  parameter int               PATTERNS  = 256,
  parameter int               WARMUP    = BIST_WARMUP,
  parameter int               DUT_LAT   = 2,
  parameter logic [WIDTH-1:0] LFSR_TAPS = BIST_TAPS,
  parameter logic [WIDTH-1:0] LFSR_SEED = 8'h01,
  parameter logic [WIDTH-1:0] GOLDEN    = 8'h00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] misr_signal,
  output logic             misr_rst,
  output logic             misr_en,
  output logic             bist_mode,
  output logic [WIDTH-1:0] pattern_out,
  output logic             pattern_valid,
  output logic             busy,
  output logic             done,
  output logic             pass
);
  localparam int CW = $clog2(max3(WARMUP, PATTERNS, DUT_LAT) + 1);
  localparam int DL = (DUT_LAT > 0) ? DUT_LAT : 1;

  bist_state_t   state, state_nxt;
  logic [CW-1:0] cnt;
  logic [DL-1:0] dly;
  logic          cnt_end, dly_out, pass_q;

  always_comb begin
    cnt_end = 1'b0;
    case (state)
      S_WARMUP: cnt_end = (cnt == CW'(WARMUP - 1));
      S_RUN:    cnt_end = (cnt == CW'(PATTERNS - 1));
      S_FLUSH:  cnt_end = (cnt == CW'(DUT_LAT - 1));
      default:  cnt_end = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_INIT;
      S_INIT:   state_nxt = S_WARMUP;
      S_WARMUP: if (cnt_end) state_nxt = S_RUN;
      S_RUN:    if (cnt_end) state_nxt = (DUT_LAT == 0) ? S_CHECK : S_FLUSH;
      S_FLUSH:  if (cnt_end) state_nxt = S_CHECK;
      S_CHECK:  state_nxt = S_DONE;
      S_DONE:   if (start) state_nxt = S_INIT;
      default:  state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  // Abort kills the live outputs in the same cycle, not just on the next edge.
  assign pattern_valid = (state == S_RUN) && !abort;
  assign dly_out       = (DUT_LAT == 0) ? pattern_valid : dly[DL-1];
  assign misr_en       = !abort && ((state == S_WARMUP) || dly_out);
  assign misr_rst      = (state == S_INIT);
  assign bist_mode     = (state != S_IDLE) && !abort;
  assign busy          = (state != S_IDLE) && (state != S_DONE);
  assign done          = (state == S_DONE);
  assign pass          = pass_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      dly    <= '0;
      pass_q <= 1'b0;
    end else begin
      state <= state_nxt;
      // Per-state cycle counter; held at zero outside the timed states so it never wraps.
      if (state_nxt != state || !busy) cnt <= '0;
      else                             cnt <= cnt + 1'b1;
      if (abort) dly <= '0;
      else begin
        for (int i = DL - 1; i > 0; i--) dly[i] <= dly[i-1];
        dly[0] <= pattern_valid;
      end
      if (abort)                      pass_q <= 1'b0;
      else if (state == S_CHECK)      pass_q <= (misr_signal == GOLDEN);
      else if (state_nxt == S_INIT)   pass_q <= 1'b0;
    end
  end

  bist_lfsr #(.WIDTH(WIDTH), .TAPS(LFSR_TAPS), .SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .load    (rst || (state == S_INIT)),
    .advance (state == S_RUN),
    .q       (pattern_out)
  );
endmodule

// File: tb/tb_bist_controller.sv
// Bench for bist_controller with a behavioural datapath + misr around each instance.
module tb_bist_controller;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, start_c = 1'b0, abort_c = 1'b0;
  int total = 0, bad = 0;
  always #5 clk = ~clk;

  function automatic logic [7:0] dp_f(logic [7:0] x);
    return (x ^ 8'h5A) + 8'h33;
  endfunction
  function automatic logic [7:0] misr_step(logic [7:0] s, logic [7:0] d);
    return ({s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00)) ^ d;
  endfunction
  function automatic logic [7:0] lfsr_nxt(logic [7:0] p);
    return {p[6:0], ^(p & 8'hB8)};
  endfunction
  function automatic logic [7:0] model_sig(int n);
    logic [7:0] p, s;
    p = 8'h01;
    s = 8'hFF;
    for (int i = 0; i < n; i++) begin
      s = misr_step(s, dp_f(p));
      p = lfsr_nxt(p);
    end
    return s;
  endfunction

  localparam logic [7:0] GOLD_A = model_sig(256);
  localparam logic [7:0] GOLD_C = model_sig(1);

  logic       misr_rst_a, misr_en_a, bist_mode_a, pv_a, busy_a, done_a, pass_a;
  logic       misr_rst_b, misr_en_b, bist_mode_b, pv_b, busy_b, done_b, pass_b;
  logic       misr_rst_c, misr_en_c, bist_mode_c, pv_c, busy_c, done_c, pass_c;
  logic [7:0] pat_a, pat_b, pat_c;
  logic [7:0] sig_a = 8'hFF, sig_c = 8'hFF, p1_a = 8'h00, p2_a = 8'h00;
  int         mc_a = 0, mc_c = 0;

  logic [7:0] q_pat[$];
  logic       q_pass[$];

  bist_controller #(.GOLDEN(GOLD_A)) dut_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .misr_signal(sig_a),
    .misr_rst(misr_rst_a), .misr_en(misr_en_a), .bist_mode(bist_mode_a), .pattern_out(pat_a),
    .pattern_valid(pv_a), .busy(busy_a), .done(done_a), .pass(pass_a));

  // Same stimulus and signature as dut_a, but built with a wrong golden value.
  bist_controller #(.GOLDEN(GOLD_A ^ 8'h01)) dut_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .misr_signal(sig_a),
    .misr_rst(misr_rst_b), .misr_en(misr_en_b), .bist_mode(bist_mode_b), .pattern_out(pat_b),
    .pattern_valid(pv_b), .busy(busy_b), .done(done_b), .pass(pass_b));

  bist_controller #(.PATTERNS(1), .DUT_LAT(0), .GOLDEN(GOLD_C)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .abort(abort_c), .misr_signal(sig_c),
    .misr_rst(misr_rst_c), .misr_en(misr_en_c), .bist_mode(bist_mode_c), .pattern_out(pat_c),
    .pattern_valid(pv_c), .busy(busy_c), .done(done_c), .pass(pass_c));

  // Two-stage datapath and misr for dut_a; combinational datapath for dut_c.
  always @(posedge clk) begin
    p1_a <= pat_a;
    p2_a <= p1_a;
  end
  always @(posedge clk) begin
    if (misr_rst_a) begin sig_a <= 8'hFF; mc_a <= 0; end
    else if (misr_en_a) begin
      if (mc_a < 17) mc_a <= mc_a + 1;
      else           sig_a <= misr_step(sig_a, dp_f(p2_a));
    end
  end
  always @(posedge clk) begin
    if (misr_rst_c) begin sig_c <= 8'hFF; mc_c <= 0; end
    else if (misr_en_c) begin
      if (mc_c < 17) mc_c <= mc_c + 1;
      else           sig_c <= misr_step(sig_c, dp_f(pat_c));
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({busy_a, done_a, pass_a, misr_en_a, misr_rst_a, bist_mode_a, pv_a} !== 7'b0) begin
      bad++; $display("FAIL reset_outs_a: got %b want 0000000",
        {busy_a, done_a, pass_a, misr_en_a, misr_rst_a, bist_mode_a, pv_a});
    end
    total++;
    if (pat_a !== 8'h01) begin bad++; $display("FAIL reset_pat_a: got %h want 01", pat_a); end
    total++;
    if ({busy_c, done_c, pass_c, misr_en_c, misr_rst_c, bist_mode_c, pv_c} !== 7'b0) begin
      bad++; $display("FAIL reset_outs_c: got %b want 0000000",
        {busy_c, done_c, pass_c, misr_en_c, misr_rst_c, bist_mode_c, pv_c});
    end
    total++;
    if (pat_c !== 8'h01) begin bad++; $display("FAIL reset_pat_c: got %h want 01", pat_c); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_run();
    logic [7:0] p, exp_pat;
    logic [7:0] first5 [5];
    logic       exp_pass;
    int done_cyc, me_cnt, pv_cnt, last_me;
    first5 = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
    done_cyc = -1; me_cnt = 0; pv_cnt = 0; last_me = -1;
    p = 8'h01;
    for (int i = 0; i < 256; i++) begin q_pat.push_back(p); p = lfsr_nxt(p); end
    q_pass.push_back(1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy_a !== 1'b1) begin bad++; $display("FAIL busy_after_start: got %b want 1", busy_a); end
    for (int cyc = 1; cyc < 400; cyc++) begin
      if (misr_en_a) begin me_cnt++; last_me = cyc; end
      if (pv_a) begin
        total++;
        if (q_pat.size() == 0) begin bad++; $display("FAIL pattern_extra: cycle %0d got %h", cyc, pat_a); end
        else begin
          exp_pat = q_pat.pop_front();
          if (pat_a !== exp_pat) begin
            bad++; $display("FAIL pattern_seq: idx %0d got %h want %h", pv_cnt, pat_a, exp_pat);
          end
        end
        if (pv_cnt < 5) begin
          total++;
          if (pat_a !== first5[pv_cnt]) begin
            bad++; $display("FAIL first_patterns: idx %0d got %h want %h", pv_cnt, pat_a, first5[pv_cnt]);
          end
        end
        pv_cnt++;
      end
      if (done_a) begin done_cyc = cyc; break; end
      @(negedge clk);
    end
    total++;
    if (done_cyc != 278) begin bad++; $display("FAIL done_latency: got %0d want 278", done_cyc); end
    total++;
    if (me_cnt != 273) begin bad++; $display("FAIL misr_en_count: got %0d want 273", me_cnt); end
    total++;
    if (last_me != 276) begin bad++; $display("FAIL misr_en_last: got %0d want 276", last_me); end
    total++;
    if (pv_cnt != 256) begin bad++; $display("FAIL pv_count: got %0d want 256", pv_cnt); end
    exp_pass = (q_pass.size() != 0) ? q_pass.pop_front() : 1'b0;
    total++;
    if (pass_a !== exp_pass) begin bad++; $display("FAIL pass_golden: got %b want %b", pass_a, exp_pass); end
    total++;
    if ({done_b, pass_b} !== 2'b10) begin
      bad++; $display("FAIL pass_wrong_golden: got done/pass %b want 10", {done_b, pass_b});
    end
    q_pat.delete();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++;
    if ({busy_a, done_a, pass_a} !== 3'b000) begin
      bad++; $display("FAIL abort_from_done: got %b want 000", {busy_a, done_a, pass_a});
    end
  endtask

  task automatic test_abort_reset();
    int seen;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (118) @(negedge clk);
    total++;
    if ({busy_a, pv_a} !== 2'b11) begin bad++; $display("FAIL run_cycle100: got %b want 11", {busy_a, pv_a}); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++;
    if ({busy_a, done_a, pass_a, misr_en_a, misr_rst_a, bist_mode_a, pv_a} !== 7'b0) begin
      bad++; $display("FAIL abort_outs: got %b want 0000000",
        {busy_a, done_a, pass_a, misr_en_a, misr_rst_a, bist_mode_a, pv_a});
    end
    seen = 0;
    repeat (300) begin @(negedge clk); if (done_a || busy_a) seen = 1; end
    total++;
    if (seen != 0) begin bad++; $display("FAIL abort_no_done: got %0d want 0", seen); end

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (274) @(negedge clk);
    total++;
    if ({busy_a, pv_a, misr_en_a} !== 3'b101) begin
      bad++; $display("FAIL flush_state: got %b want 101", {busy_a, pv_a, misr_en_a});
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({busy_a, done_a, pass_a, misr_en_a, misr_rst_a, bist_mode_a, pv_a} !== 7'b0) begin
      bad++; $display("FAIL rst_flush_outs: got %b want 0000000",
        {busy_a, done_a, pass_a, misr_en_a, misr_rst_a, bist_mode_a, pv_a});
    end
    total++;
    if (pat_a !== 8'h01) begin bad++; $display("FAIL rst_flush_pat: got %h want 01", pat_a); end
    seen = 0;
    repeat (300) begin @(negedge clk); if (done_a || busy_a) seen = 1; end
    total++;
    if (seen != 0) begin bad++; $display("FAIL rst_no_done: got %0d want 0", seen); end
  endtask

  task automatic test_start_held();
    int done_cyc, init_cnt;
    done_cyc = -1; init_cnt = 0;
    q_pass.push_back(1'b1);
    start = 1'b1;
    @(negedge clk);
    for (int cyc = 1; cyc < 400; cyc++) begin
      if (misr_rst_a) init_cnt++;
      if (done_a) begin done_cyc = cyc; break; end
      @(negedge clk);
    end
    total++;
    if (done_cyc != 278) begin bad++; $display("FAIL held_done_latency: got %0d want 278", done_cyc); end
    total++;
    if (init_cnt != 1) begin bad++; $display("FAIL held_single_run: got %0d want 1", init_cnt); end
    total++;
    if (pass_a !== q_pass.pop_front()) begin bad++; $display("FAIL held_pass: got %b want 1", pass_a); end
    @(negedge clk);
    total++;
    if ({misr_rst_a, busy_a, done_a, pass_a} !== 4'b1100) begin
      bad++; $display("FAIL restart_init: got %b want 1100", {misr_rst_a, busy_a, done_a, pass_a});
    end
    start = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++;
    if ({busy_a, done_a} !== 2'b00) begin bad++; $display("FAIL abort_init: got %b want 00", {busy_a, done_a}); end
  endtask

  task automatic test_edge_params();
    int done_cyc, me_cnt, pv_cnt;
    logic [7:0] exp_pat;
    done_cyc = -1; me_cnt = 0; pv_cnt = 0;
    q_pat.push_back(8'h01);
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    for (int cyc = 1; cyc < 100; cyc++) begin
      if (misr_en_c) me_cnt++;
      if (pv_c) begin
        pv_cnt++;
        exp_pat = (q_pat.size() != 0) ? q_pat.pop_front() : 8'hXX;
        total++;
        if (pat_c !== exp_pat) begin bad++; $display("FAIL edge_pattern: got %h want %h", pat_c, exp_pat); end
      end
      if (done_c) begin done_cyc = cyc; break; end
      @(negedge clk);
    end
    total++;
    if (done_cyc != 21) begin bad++; $display("FAIL edge_done_latency: got %0d want 21", done_cyc); end
    total++;
    if (me_cnt != 18) begin bad++; $display("FAIL edge_misr_en: got %0d want 18", me_cnt); end
    total++;
    if (pv_cnt != 1) begin bad++; $display("FAIL edge_pv_count: got %0d want 1", pv_cnt); end
    total++;
    if (pass_c !== 1'b1) begin bad++; $display("FAIL edge_pass: got %b want 1", pass_c); end
    q_pat.delete();
    abort_c = 1'b1;
    @(negedge clk);
    abort_c = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_full_run();
    test_abort_reset();
    test_start_held();
    test_edge_params();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
